traffic_phase_sequencer: RTL and testbench
==========================================

# traffic_phase_sequencer

Timed two-road traffic-light sequencer for the highway/country intersection. It adds dwell timers, a minimum/maximum country-green window, an all-red clearance interval and a latched pedestrian request to the basic sensor-driven light sequence. It sits between the board I/O (sensor switch, pedestrian button) and the light drivers, and runs from the 50 MHz board clock.

## Interface
- TICK_DIV, 50_000_000: clock cycles per timing tick (1 s at 50 MHz); legal range ≥2.
- HWY_MIN_G, 10: minimum highway green, in ticks.
- YEL, 3: yellow duration, in ticks (both roads).
- ALLRED, 1: all-red clearance, in ticks.
- CTRY_MIN_G, 3: minimum country green, in ticks.
- CTRY_MAX_G, 8: maximum country green, in ticks; must be ≥ CTRY_MIN_G.
- All tick parameters: range 1..255; elaboration error otherwise.
- CLOCK_50  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- sensor  in  1  country-road vehicle sensor; asynchronous level.
- ped_req  in  1  pedestrian request; synchronous one-cycle pulse.
- hwy  out  2  highway light code (G=00, Y=01, R=10).
- cntry  out  2  country light code (same encoding).
- walk  out  1  pedestrian walk lamp; high only in CG.
- state  out  3  current state code, for debug LEDs.

## Operation
- States and codes: HG=0 (hwy G, cntry R), HY=1 (Y,R), AR1=2 (R,R), CG=3 (R,G), CY=4 (R,Y), AR2=5 (R,R). Codes 6/7 are illegal and go to HG on the next edge.
- sensor passes through a 2-flop synchronizer, giving sensor_s.
- ped_pending is set by ped_req and cleared on the edge that enters CG. If ped_req coincides with CG entry, the clear wins: the request counts as served.
- elapsed: 8-bit tick count within the current state. It is zeroed on every state change and incremented on each tick that does not cause an exit.
- Exit conditions, evaluated only on a tick cycle:
  - HG → HY when elapsed ≥ HWY_MIN_G-1 and (sensor_s or ped_pending).
  - HY → AR1 when elapsed == YEL-1.
  - AR1 → CG when elapsed == ALLRED-1.
  - CG → CY when (elapsed ≥ CTRY_MIN_G-1 and !sensor_s) or elapsed == CTRY_MAX_G-1.
  - CY → AR2 when elapsed == YEL-1.
  - AR2 → HG when elapsed == ALLRED-1.
- With no demand, HG holds indefinitely. elapsed saturates at 255.
- Outputs hwy, cntry, walk and state are registered. They update on the same edge as the state register and never glitch.

## Timing
- On clear assertion, immediately (asynchronously): state=HG, hwy=00, cntry=10, walk=0, ped_pending=0, elapsed=0, prescaler=0, synchronizer flops=0.
- clear mid-phase aborts the phase. After release, the full HWY_MIN_G restarts.
- Prescaler counts 0..TICK_DIV-1 and asserts tick when the count equals TICK_DIV-1. It restarts at 0 on every state change and on clear.
- A state dwelling N ticks therefore lasts exactly N·TICK_DIV cycles.
- Sensor latency: sensor change to sensor_s is 2 cycles. Exit decisions use sensor_s sampled on the tick cycle.
- ped_req is effective on the edge where it is sampled high; it is seen by an exit decision on the same cycle's tick only from the following cycle.

## Structure
- traffic_pkg holds:
  - state enum (HG..AR2) and the light-code constants G/Y/R;
  - the output-decode function from state to {hwy, cntry, walk}.
- Sub-module tick_prescaler (parameter TICK_DIV; ports CLOCK_50, clear, restart, tick).
- The FSM, elapsed counter, synchronizer and ped latch stay in the top module.

## Test plan
All scenarios use TICK_DIV=4, HWY_MIN_G=3, YEL=2, ALLRED=1, CTRY_MIN_G=2, CTRY_MAX_G=4.
- Reset, sensor=0, ped_req=0 for 200 cycles → state=0, hwy=00, cntry=10, walk=0 throughout.
- sensor=1 held from reset release → HG 12, HY 8, AR1 4, CG 16 (max), CY 8, AR2 4 cycles, then HG again. Sequence repeats while sensor stays high.
- sensor=1 until 2 cycles after CG entry, then 0 → CG lasts exactly 8 cycles (min green), then CY.
- One ped_req pulse mid-HG, sensor=0 → full cycle runs. walk=1 only during CG (8 cycles); after AR2, HG holds indefinitely.
- clear pulsed mid-CG → outputs become hwy=00, cntry=10, walk=0, state=0 before the next clock edge. With sensor=1, the next HY comes 12 cycles after release.
- ped_req on the AR1→CG edge, sensor=0 → CG 8 cycles; after return to HG, no further cycle occurs (ped_pending=0).

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: state codes, light codes and the state-to-lights decode for the intersection sequencer.
package traffic_pkg;

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5
    } state_t;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;

    typedef struct packed {
        logic [1:0] hwy;
        logic [1:0] cntry;
        logic       walk;
    } lights_t;

    // Unused codes decode as HG so the lamps stay safe while the FSM recovers.
    function automatic lights_t decode(input state_t s);
        case (s)
            HY:       return lights_t'({Y, R, 1'b0});
            AR1, AR2: return lights_t'({R, R, 1'b0});
            CG:       return lights_t'({R, G, 1'b1});
            CY:       return lights_t'({R, Y, 1'b0});
            default:  return lights_t'({G, R, 1'b0});
        endcase
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the board clock into one-cycle ticks, restartable on phase change.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic clear,
    input  logic restart,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);

    logic [W-1:0] cnt;

    assign tick = cnt == W'(TICK_DIV - 1);

    always_ff @(posedge CLOCK_50 or posedge clear) begin
        if (clear)
            cnt <= '0;
        else
            cnt <= (restart || tick) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: timed highway/country light sequencer with clearance interval,
// country-green window and latched pedestrian request.
module traffic_phase_sequencer #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int HWY_MIN_G  = 10,
    parameter int YEL        = 3,
    parameter int ALLRED     = 1,
    parameter int CTRY_MIN_G = 3,
    parameter int CTRY_MAX_G = 8
) (
    input  logic       CLOCK_50,
    input  logic       clear,
    input  logic       sensor,
    input  logic       ped_req,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk,
    output logic [2:0] state
);

    import traffic_pkg::*;

    if (TICK_DIV < 2 ||
        HWY_MIN_G < 1 || HWY_MIN_G > 255 || YEL < 1 || YEL > 255 ||
        ALLRED < 1 || ALLRED > 255 || CTRY_MIN_G < 1 || CTRY_MIN_G > 255 ||
        CTRY_MAX_G < 1 || CTRY_MAX_G > 255 || CTRY_MAX_G < CTRY_MIN_G) begin : g_bad_params
        $error("traffic_phase_sequencer: illegal timing parameters");
    end

    state_t     st;
    state_t     target;
    lights_t    lt;
    logic [7:0] elapsed;
    logic [1:0] sync;
    logic       sensor_s;
    logic       ped_pending;
    logic       tick;
    logic       exit_now;
    logic       go;

    assign sensor_s = sync[1];
    assign go       = st > AR2 || (tick && exit_now);
    assign target   = (st >= AR2) ? HG : state_t'(st + 3'd1);
    assign state    = st;
    assign hwy      = lt.hwy;
    assign cntry    = lt.cntry;
    assign walk     = lt.walk;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLOCK_50 (CLOCK_50),
        .clear    (clear),
        .restart  (go),
        .tick     (tick)
    );

    always_comb begin
        exit_now = 1'b0;
        case (st)
            HG:       exit_now = elapsed >= 8'(HWY_MIN_G - 1) && (sensor_s || ped_pending);
            HY, CY:   exit_now = elapsed == 8'(YEL - 1);
            AR1, AR2: exit_now = elapsed == 8'(ALLRED - 1);
            CG:       exit_now = (elapsed >= 8'(CTRY_MIN_G - 1) && !sensor_s) ||
                                 elapsed == 8'(CTRY_MAX_G - 1);
            default:  exit_now = 1'b0;
        endcase
    end

    // A request arriving on the CG-entry edge is served by that green.
    always_ff @(posedge CLOCK_50 or posedge clear) begin
        if (clear) begin
            sync        <= '0;
            st          <= HG;
            elapsed     <= '0;
            ped_pending <= 1'b0;
            lt          <= decode(HG);
        end else begin
            sync        <= {sync[0], sensor};
            ped_pending <= (go && target == CG) ? 1'b0 : (ped_pending | ped_req);
            if (go) begin
                st      <= target;
                elapsed <= '0;
                lt      <= decode(target);
            end else if (tick && elapsed != 8'hFF) begin
                elapsed <= elapsed + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer: phase-timing reference model feeding a scoreboard, plus
// directed phase-duration checks and a randomized soak.
module tb_traffic_phase_sequencer;

    localparam int TD = 4, HMG = 3, YL = 2, AR = 1, CMIN = 2, CMAX = 4;

    logic       clk = 0, clear = 0, sensor = 0, ped_req = 0;
    logic [1:0] hwy, cntry;
    logic       walk;
    logic [2:0] state;

    traffic_phase_sequencer #(
        .TICK_DIV(TD), .HWY_MIN_G(HMG), .YEL(YL), .ALLRED(AR),
        .CTRY_MIN_G(CMIN), .CTRY_MAX_G(CMAX)
    ) dut (
        .CLOCK_50 (clk),
        .clear    (clear),
        .sensor   (sensor),
        .ped_req  (ped_req),
        .hwy      (hwy),
        .cntry    (cntry),
        .walk     (walk),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct { int st; int len; } run_t;

    int n_cmp = 0, n_bad = 0;
    logic [7:0] q[$];
    run_t runs[$];
    int run_st = 0, run_len = 1, walk_cnt = 0;

    // Reference model: phase index, cycles spent in phase, sensor history, pending request.
    int ph = 0, cyc = 0;
    bit h0 = 0, h1 = 0, pend = 0;
    int hw_code[6] = '{0, 1, 2, 2, 2, 2};
    int cn_code[6] = '{2, 2, 2, 0, 1, 2};

    function automatic logic [7:0] dut_out();
        return {state, hwy, cntry, walk};
    endfunction

    function automatic logic [7:0] exp_out(input int p);
        return {3'(p), 2'(hw_code[p]), 2'(cn_code[p]), 1'(p == 3)};
    endfunction

    function automatic bit exit_ok(input int p, input int n, input bit ss, input bit pd);
        case (p)
            0:       return n >= HMG - 1 && (ss || pd);
            1, 4:    return n == YL - 1;
            2, 5:    return n == AR - 1;
            3:       return (n >= CMIN - 1 && !ss) || n == CMAX - 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit leaving();
        return cyc % TD == TD - 1 && exit_ok(ph, cyc / TD, h1, pend);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_run(input string name, input int idx, input int st, input int len);
        chk(name, idx < runs.size() ? runs[idx].st * 1000 + runs[idx].len : -1, st * 1000 + len);
    endtask

    task automatic model_edge(input bit s, input bit p, input bit c);
        if (c) begin
            ph = 0; cyc = 0; h0 = 0; h1 = 0; pend = 0;
        end else begin
            if (leaving()) begin
                ph = (ph + 1) % 6;
                cyc = 0;
                pend = (ph == 3) ? 1'b0 : (pend | p);
            end else begin
                cyc++;
                pend = pend | p;
            end
            h1 = h0;
            h0 = s;
        end
        q.push_back(exp_out(ph));
    endtask

    task automatic step(input bit s, input bit p, input bit c);
        @(negedge clk);
        #1;
        sensor = s;
        ped_req = p;
        if (c) begin
            clear = 1;
            #1;
            chk("clear_async", int'(dut_out()), int'(8'h04));
        end else begin
            if (clear) begin
                runs.delete();
                run_st = 0;
                run_len = 1;
                walk_cnt = 0;
            end
            clear = 0;
        end
        @(posedge clk);
        model_edge(s, p, c);
    endtask

    task automatic start();
        step(0, 0, 1);
        step(0, 0, 1);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) chk("cycle", int'(dut_out()), int'(q.pop_front()));
        if (int'(state) == run_st) run_len++;
        else begin
            runs.push_back('{run_st, run_len});
            run_st = int'(state);
            run_len = 1;
        end
        walk_cnt += int'(walk);
    end

    initial begin
        bit found, s;
        // Idle: no demand keeps HG forever.
        start();
        repeat (200) step(0, 0, 0);
        chk("idle_runs", runs.size(), 0);
        chk("idle_walk", walk_cnt, 0);

        // Constant demand: full cycle with max country green, repeating.
        start();
        repeat (130) step(1, 0, 0);
        chk_run("hold_hg", 0, 0, 12);
        chk_run("hold_hy", 1, 1, 8);
        chk_run("hold_ar1", 2, 2, 4);
        chk_run("hold_cg_max", 3, 3, 16);
        chk_run("hold_cy", 4, 4, 8);
        chk_run("hold_ar2", 5, 5, 4);
        chk_run("hold_hg2", 6, 0, 12);

        // Sensor drops just after CG entry: minimum green.
        start();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1, 0, 0);
            found = ph == 3;
        end
        chk("reach_cg", found, 1);
        step(1, 0, 0);
        step(1, 0, 0);
        repeat (60) step(0, 0, 0);
        chk_run("min_green", 3, 3, 8);

        // Single pedestrian pulse: one cycle, then HG holds.
        start();
        repeat (5) step(0, 0, 0);
        step(0, 1, 0);
        repeat (200) step(0, 0, 0);
        chk_run("ped_hg", 0, 0, 12);
        chk_run("ped_cg", 3, 3, 8);
        chk_run("ped_ar2", 5, 5, 4);
        chk("ped_one_cycle", runs.size(), 6);
        chk("ped_walk_cycles", walk_cnt, 8);

        // Clear mid-CG aborts the phase; HG restarts in full.
        start();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1, 0, 0);
            found = ph == 3;
        end
        chk("reach_cg2", found, 1);
        repeat (3) step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        repeat (30) step(1, 0, 0);
        chk_run("hg_after_clear", 0, 0, 12);

        // Request landing on the CG-entry edge is absorbed by that green.
        start();
        repeat (3) step(0, 0, 0);
        step(0, 1, 0);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (ph == 2 && leaving()) begin
                step(0, 1, 0);
                found = 1;
            end else step(0, 0, 0);
        end
        chk("hit_cg_edge", found, 1);
        repeat (150) step(0, 0, 0);
        chk_run("edge_cg", 3, 3, 8);
        chk("edge_no_repeat", runs.size(), 6);

        // Randomized soak against the scoreboard.
        start();
        s = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) s = !s;
            step(s, $urandom_range(39) == 0, $urandom_range(599) == 0);
        end
        @(negedge clk);
        #1;
        chk("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
